bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning slave wait cycles before error-ack (0 disables timeout).
REQ-002 SHALL have parameter ERR_DATA, default 16'hFFFF, meaning read data returned on timeout.
REQ-003 SHALL have port i_clk  in  1  clock, all logic on rising edge.
REQ-004 SHALL have port i_reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports i_m0_addr/i_m0_dat  in  16 each  master 0 (CPU) address / write data.
REQ-006 SHALL have ports i_m0_bs  in  2  and i_m0_we  in  1  master 0 byte select / write enable.
REQ-007 SHALL have ports o_m0_dat  out  16  and o_m0_ack  out  1  master 0 read data / acknowledge.
REQ-008 SHALL have ports i_m1_addr, i_m1_dat, i_m1_bs, i_m1_we, o_m1_dat, o_m1_ack, mirroring master 0 (DMA/loader master).
REQ-009 SHALL have ports o_s_addr  out  16, o_s_dat  out  16, o_s_bs  out  2, o_s_we  out  1  (slave request).
REQ-010 SHALL have ports i_s_dat  in  16 and i_s_ack  in  1  (slave response).
REQ-011 SHALL have ports o_grant  out  2  (one-hot owner) and o_timeout  out  1  (one-cycle error pulse).

Function
REQ-012 SHALL treat a master as requesting when its bs != 2'b00; we is qualified by bs.
REQ-013 SHALL implement states IDLE, GRANT0, GRANT1; reset state IDLE.
REQ-014 SHALL in IDLE: one requester -> grant it; both -> grant the master not last served (round-robin, last_served resets to 1 so m0 wins first); none -> stay IDLE.
REQ-015 SHALL register the grant: request seen in cycle n -> slave request driven in cycle n+1.
REQ-016 SHALL in GRANTx drive o_s_addr/dat/bs/we from master x combinationally; o_grant = one-hot x.
REQ-017 SHALL in IDLE drive o_s_bs = 2'b00, o_s_we = 0, o_s_addr/o_s_dat = 0, o_grant = 0.
REQ-018 SHALL pass i_s_ack to o_mx_ack and i_s_dat to o_mx_dat combinationally for granted master only; non-granted master sees ack 0, data 0.
REQ-019 SHALL on i_s_ack in GRANTx: set last_served = x, next state IDLE (one idle cycle between transfers).
REQ-020 SHALL abort with no ack if the granted master's bs drops to 00 during GRANTx: next state IDLE, last_served unchanged.
REQ-021 SHALL count cycles in GRANTx without i_s_ack; counter clears on entry to GRANTx.
REQ-022 SHALL when TIMEOUT != 0 and count reaches TIMEOUT: o_mx_ack = 1, o_mx_dat = ERR_DATA, o_s_bs = 00, o_s_we = 0, o_timeout = 1 for that cycle, last_served = x, next state IDLE.
REQ-023 SHALL give i_s_ack priority over timeout in the same cycle (normal completion, no o_timeout).
REQ-024 SHALL ignore i_s_ack while IDLE.
REQ-025 SHALL size counter ceil(log2(TIMEOUT+1)) bits, saturating, never wrapping.

Reset
REQ-026 SHALL on i_reset (including mid-transfer) enter IDLE, clear counter, set last_served = 1, with all outputs 0 in the reset cycle and no ack issued.

Structure
REQ-027 SHALL take state encoding, default TIMEOUT and ERR_DATA constants from shared package prim_bus_pkg.
REQ-028 SHALL place the timeout counter in sub-module bus_timeout (inputs: clear, run, ack; output: expired).

Verification
REQ-029 SHALL test m0 read 0x0100 alone, slave acks 2 cycles after grant with 0x1234 -> o_m0_ack one cycle, o_m0_dat=0x1234, o_grant 01 then 00.
REQ-030 SHALL test m0 and m1 requesting same cycle after reset, back-to-back -> grants m0, IDLE, m1, IDLE, m0.
REQ-031 SHALL test m1 write 0xBEEF to 0x2000 bs=11 -> o_s_we=1, o_s_dat=0xBEEF, o_s_addr=0x2000; m0 sees no ack.
REQ-032 SHALL test TIMEOUT=4 with slave never acking -> ack on 4th grant cycle, data 0xFFFF, o_timeout pulse; ack on that exact cycle -> no o_timeout.
REQ-033 SHALL test i_reset asserted mid-grant and m0 bs dropping mid-grant -> IDLE next cycle, o_s_bs=00, no master ack.

Source files
------------

// File: rtl/prim_bus_pkg.sv
// Shared constants and state encoding for the two-master bus arbiter.
package prim_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  localparam int          DEFAULT_TIMEOUT  = 255;
  localparam logic [15:0] DEFAULT_ERR_DATA = 16'hFFFF;

  // Wide enough to hold 0..t; never narrower than one bit so TIMEOUT=0 still elaborates.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/bus_timeout.sv
// Saturating wait counter for a granted slave cycle; flags the cycle that reaches TIMEOUT.
module bus_timeout
  import prim_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic run,
  input  logic ack,
  output logic expired
);

  localparam int            CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  logic [CW-1:0] count_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      count_reg <= '0;
    end else if (run && !ack && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // count_reg holds completed wait cycles, so the current cycle is wait number count_reg+1.
  assign expired = (TIMEOUT != 0) && run && !ack && (count_reg >= CNT_LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto a single slave port, with slave-timeout error ack.
module bus_arbiter
  import prim_bus_pkg::*;
#(
  parameter int          TIMEOUT  = DEFAULT_TIMEOUT,
  parameter logic [15:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_m0_addr,
  input  logic [15:0] i_m0_dat,
  input  logic [1:0]  i_m0_bs,
  input  logic        i_m0_we,
  output logic [15:0] o_m0_dat,
  output logic        o_m0_ack,
  input  logic [15:0] i_m1_addr,
  input  logic [15:0] i_m1_dat,
  input  logic [1:0]  i_m1_bs,
  input  logic        i_m1_we,
  output logic [15:0] o_m1_dat,
  output logic        o_m1_ack,
  output logic [15:0] o_s_addr,
  output logic [15:0] o_s_dat,
  output logic [1:0]  o_s_bs,
  output logic        o_s_we,
  input  logic [15:0] i_s_dat,
  input  logic        i_s_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  arb_state_t  state_reg;
  logic        last_served_reg;
  logic [1:0]  grant_reg;

  logic        req0, req1;
  logic        granted0, granted1, active;
  logic [15:0] sel_addr, sel_dat;
  logic [1:0]  sel_bs;
  logic        sel_we, sel_req;
  logic        expired;
  logic        resp_ack;
  logic [15:0] resp_dat;

  assign req0 = |i_m0_bs;
  assign req1 = |i_m1_bs;

  // Reset masks the bus immediately, even while the state register still holds a grant.
  assign granted0 = (state_reg == ST_GRANT0) && !i_reset;
  assign granted1 = (state_reg == ST_GRANT1) && !i_reset;
  assign active   = granted0 || granted1;

  assign sel_addr = granted1 ? i_m1_addr : i_m0_addr;
  assign sel_dat  = granted1 ? i_m1_dat  : i_m0_dat;
  assign sel_bs   = granted1 ? i_m1_bs   : i_m0_bs;
  assign sel_we   = granted1 ? i_m1_we   : i_m0_we;
  assign sel_req  = |sel_bs;

  bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clear   (state_reg == ST_IDLE),
    .run     (active && sel_req),
    .ack     (i_s_ack),
    .expired (expired)
  );

  assign resp_ack = (active && sel_req && i_s_ack) || expired;
  assign resp_dat = expired ? ERR_DATA : i_s_dat;

  always_comb begin
    o_s_addr = '0;
    o_s_dat  = '0;
    o_s_bs   = 2'b00;
    o_s_we   = 1'b0;
    if (active) begin
      o_s_addr = sel_addr;
      o_s_dat  = sel_dat;
      o_s_bs   = expired ? 2'b00 : sel_bs;
      o_s_we   = sel_we && sel_req && !expired;
    end
  end

  assign o_m0_ack  = granted0 && resp_ack;
  assign o_m1_ack  = granted1 && resp_ack;
  assign o_m0_dat  = granted0 ? resp_dat : 16'h0000;
  assign o_m1_dat  = granted1 ? resp_dat : 16'h0000;
  assign o_timeout = expired;
  assign o_grant   = grant_reg & {2{!i_reset}};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg       <= ST_IDLE;
      last_served_reg <= 1'b1;
      grant_reg       <= 2'b00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // last_served_reg==1 means m1 went last, so m0 wins a tie.
          if (req0 && (!req1 || last_served_reg)) begin
            state_reg <= ST_GRANT0;
            grant_reg <= 2'b01;
          end else if (req1) begin
            state_reg <= ST_GRANT1;
            grant_reg <= 2'b10;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (!sel_req) begin
            state_reg <= ST_IDLE;
            grant_reg <= 2'b00;
          end else if (i_s_ack || expired) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= 2'b00;
            last_served_reg <= (state_reg == ST_GRANT1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          grant_reg <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int          TO  = 4;
  localparam logic [15:0] ERR = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m0_addr, m0_wdat, m1_addr, m1_wdat, s_rdat;
  logic [1:0]  m0_bs, m1_bs;
  logic        m0_we, m1_we, s_ack;
  logic [15:0] m0_rdat, m1_rdat, s_addr, s_wdat;
  logic        m0_ack, m1_ack, s_we, tmo;
  logic [1:0]  s_bs, grant;

  int nchecks = 0;
  int nerrors = 0;

  // Reference model: who owns the bus (0 none, 1 m0, 2 m1), who went last, cycles waited.
  int mdl_owner, mdl_last, mdl_waited;
  logic [1:0]  exp_grant, exp_s_bs;
  logic [15:0] exp_s_addr, exp_s_dat, exp_m0_dat, exp_m1_dat;
  logic        exp_s_we, exp_m0_ack, exp_m1_ack, exp_to;

  bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_addr(m0_addr), .i_m0_dat(m0_wdat), .i_m0_bs(m0_bs), .i_m0_we(m0_we),
    .o_m0_dat(m0_rdat), .o_m0_ack(m0_ack),
    .i_m1_addr(m1_addr), .i_m1_dat(m1_wdat), .i_m1_bs(m1_bs), .i_m1_we(m1_we),
    .o_m1_dat(m1_rdat), .o_m1_ack(m1_ack),
    .o_s_addr(s_addr), .o_s_dat(s_wdat), .o_s_bs(s_bs), .o_s_we(s_we),
    .i_s_dat(s_rdat), .i_s_ack(s_ack),
    .o_grant(grant), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic model_eval();
    logic [1:0]  bs;
    logic        rack;
    logic [15:0] rdat;
    exp_grant = 0; exp_s_bs = 0; exp_s_addr = 0; exp_s_dat = 0; exp_s_we = 0;
    exp_m0_ack = 0; exp_m1_ack = 0; exp_m0_dat = 0; exp_m1_dat = 0; exp_to = 0;
    rack = 0; rdat = 0;
    if (!rst && mdl_owner != 0) begin
      bs         = (mdl_owner == 2) ? m1_bs : m0_bs;
      exp_grant  = (mdl_owner == 2) ? 2'b10 : 2'b01;
      exp_s_addr = (mdl_owner == 2) ? m1_addr : m0_addr;
      exp_s_dat  = (mdl_owner == 2) ? m1_wdat : m0_wdat;
      rdat       = s_rdat;
      if (bs == 2'b00) begin
        rack = 0;
      end else if (s_ack) begin
        exp_s_bs = bs; exp_s_we = (mdl_owner == 2) ? m1_we : m0_we; rack = 1;
      end else if (mdl_waited + 1 >= TO) begin
        rack = 1; rdat = ERR; exp_to = 1;
      end else begin
        exp_s_bs = bs; exp_s_we = (mdl_owner == 2) ? m1_we : m0_we;
      end
      if (mdl_owner == 1) begin exp_m0_ack = rack; exp_m0_dat = rdat; end
      else begin exp_m1_ack = rack; exp_m1_dat = rdat; end
    end
  endtask

  task automatic model_step();
    logic [1:0] bs;
    if (rst) begin
      mdl_owner = 0; mdl_last = 1; mdl_waited = 0;
    end else if (mdl_owner == 0) begin
      if (m0_bs != 0 && (m1_bs == 0 || mdl_last == 1)) mdl_owner = 1;
      else if (m1_bs != 0) mdl_owner = 2;
      mdl_waited = 0;
    end else begin
      bs = (mdl_owner == 2) ? m1_bs : m0_bs;
      if (bs == 0) mdl_owner = 0;
      else if (s_ack || mdl_waited + 1 >= TO) begin
        mdl_last = mdl_owner - 1; mdl_owner = 0;
      end else mdl_waited++;
    end
  endtask

  // Advance one clock; inputs are driven in the low phase and held across the rising edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_bs = 0; m1_bs = 0; m0_we = 0; m1_we = 0; s_ack = 0; s_rdat = 0;
    m0_addr = 0; m1_addr = 0; m0_wdat = 0; m1_wdat = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; m0_bs = 2'b11; m1_bs = 2'b11; s_ack = 1; m0_addr = 16'h1111;
    tick(); #1;
    nchecks++; if (grant !== 2'b00) begin nerrors++; $display("FAIL reset_grant: got %b want 00", grant); end
    nchecks++; if (s_bs !== 2'b00 || s_addr !== 16'h0) begin nerrors++; $display("FAIL reset_slave: got bs=%b addr=%h want 00/0000", s_bs, s_addr); end
    nchecks++; if (m0_ack !== 0 || m1_ack !== 0 || tmo !== 0) begin nerrors++; $display("FAIL reset_ack: got %b%b to=%b want 00 to=0", m0_ack, m1_ack, tmo); end
    tick();
    rst = 0; m0_bs = 0; m1_bs = 0; #1;
    nchecks++; if (grant !== 2'b00 || m0_ack !== 0 || m1_ack !== 0) begin nerrors++; $display("FAIL idle_ack_ignored: got grant=%b ack=%b%b want 00/00", grant, m0_ack, m1_ack); end
    tick();
    s_ack = 0;
  endtask

  task automatic test_m0_read();
    m0_addr = 16'h0100; m0_bs = 2'b11; m0_we = 0; #1;
    nchecks++; if (grant !== 2'b00) begin nerrors++; $display("FAIL read_latency: got grant %b want 00", grant); end
    tick(); #1;
    nchecks++; if (grant !== 2'b01 || s_addr !== 16'h0100 || s_bs !== 2'b11 || s_we !== 0) begin
      nerrors++; $display("FAIL read_grant: got g=%b a=%h bs=%b we=%b want 01/0100/11/0", grant, s_addr, s_bs, s_we); end
    tick(); #1;
    nchecks++; if (m0_ack !== 0) begin nerrors++; $display("FAIL read_early_ack: got %b want 0", m0_ack); end
    tick();
    s_ack = 1; s_rdat = 16'h1234; #1;
    nchecks++; if (m0_ack !== 1 || m0_rdat !== 16'h1234 || m1_ack !== 0 || m1_rdat !== 0 || tmo !== 0) begin
      nerrors++; $display("FAIL read_ack: got ack=%b dat=%h m1=%b/%h to=%b want 1/1234 0/0000 0", m0_ack, m0_rdat, m1_ack, m1_rdat, tmo); end
    $display("txn m0 read addr=0100 data=%h", m0_rdat);
    tick();
    s_ack = 0; m0_bs = 0; #1;
    nchecks++; if (grant !== 2'b00 || m0_ack !== 0) begin nerrors++; $display("FAIL read_release: got g=%b ack=%b want 00/0", grant, m0_ack); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [5];
    seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b10; seq[3] = 2'b00; seq[4] = 2'b01;
    rst = 1; tick(); rst = 0;
    m0_bs = 2'b11; m1_bs = 2'b11; m0_addr = 16'h0A00; m1_addr = 16'h0B00; s_ack = 1; s_rdat = 16'h00C3; #1;
    nchecks++; if (grant !== 2'b00) begin nerrors++; $display("FAIL b2b_idle: got %b want 00", grant); end
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      nchecks++; if (grant !== seq[i] || {m1_ack, m0_ack} !== seq[i]) begin
        nerrors++; $display("FAIL b2b_seq%0d: got grant=%b ack=%b%b want %b", i, grant, m1_ack, m0_ack, seq[i]); end
      if (seq[i] != 0) $display("txn b2b grant=%b addr=%h", grant, s_addr);
      tick();
    end
    m0_bs = 0; m1_bs = 0; s_ack = 0;
    tick(); tick();
  endtask

  task automatic test_m1_write();
    m1_addr = 16'h2000; m1_wdat = 16'hBEEF; m1_bs = 2'b11; m1_we = 1;
    tick();
    s_ack = 1; #1;
    nchecks++; if (s_we !== 1 || s_wdat !== 16'hBEEF || s_addr !== 16'h2000 || grant !== 2'b10) begin
      nerrors++; $display("FAIL write_bus: got we=%b d=%h a=%h g=%b want 1/BEEF/2000/10", s_we, s_wdat, s_addr, grant); end
    nchecks++; if (m1_ack !== 1 || m0_ack !== 0 || m0_rdat !== 0) begin
      nerrors++; $display("FAIL write_ack: got m1=%b m0=%b/%h want 1 0/0000", m1_ack, m0_ack, m0_rdat); end
    $display("txn m1 write addr=2000 data=BEEF");
    tick();
    m1_bs = 0; m1_we = 0; s_ack = 0;
    tick();
  endtask

  task automatic test_timeout();
    m0_addr = 16'h3000; m0_bs = 2'b01; s_rdat = 16'h5A5A;
    tick();
    for (int k = 1; k <= 4; k++) begin
      #1;
      if (k < 4) begin
        nchecks++; if (m0_ack !== 0 || tmo !== 0) begin nerrors++; $display("FAIL tmo_wait%0d: got ack=%b to=%b want 0/0", k, m0_ack, tmo); end
      end else begin
        nchecks++; if (m0_ack !== 1 || m0_rdat !== 16'hFFFF || tmo !== 1 || s_bs !== 2'b00 || s_we !== 0) begin
          nerrors++; $display("FAIL tmo_fire: got ack=%b d=%h to=%b bs=%b we=%b want 1/FFFF/1/00/0", m0_ack, m0_rdat, tmo, s_bs, s_we); end
        $display("txn m0 read addr=3000 timeout data=%h", m0_rdat);
      end
      tick();
    end
    #1;
    nchecks++; if (grant !== 2'b00 || tmo !== 0) begin nerrors++; $display("FAIL tmo_idle: got g=%b to=%b want 00/0", grant, tmo); end
    tick();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) s_ack = 1;
      #1;
      if (k == 4) begin
        nchecks++; if (m0_ack !== 1 || m0_rdat !== 16'h5A5A || tmo !== 0 || s_bs !== 2'b01) begin
          nerrors++; $display("FAIL tmo_ack_prio: got ack=%b d=%h to=%b bs=%b want 1/5A5A/0/01", m0_ack, m0_rdat, tmo, s_bs); end
      end
      tick();
    end
    s_ack = 0; m0_bs = 0;
    tick();
  endtask

  task automatic test_abort();
    m0_addr = 16'h4000; m0_bs = 2'b11; m0_we = 1;
    tick(); #1;
    nchecks++; if (grant !== 2'b01) begin nerrors++; $display("FAIL abort_grant: got %b want 01", grant); end
    tick();
    rst = 1; s_ack = 1; #1;
    nchecks++; if (s_bs !== 2'b00 || m0_ack !== 0 || grant !== 2'b00 || s_we !== 0) begin
      nerrors++; $display("FAIL mid_reset: got bs=%b ack=%b g=%b we=%b want 00/0/00/0", s_bs, m0_ack, grant, s_we); end
    tick();
    rst = 0; #1;
    nchecks++; if (grant !== 2'b00 || s_bs !== 2'b00 || m0_ack !== 0) begin
      nerrors++; $display("FAIL after_reset: got g=%b bs=%b ack=%b want 00/00/0", grant, s_bs, m0_ack); end
    s_ack = 0;
    tick(); #1;
    nchecks++; if (grant !== 2'b01) begin nerrors++; $display("FAIL regrant: got %b want 01", grant); end
    tick();
    m0_bs = 0; s_ack = 1; #1;
    nchecks++; if (m0_ack !== 0 || s_bs !== 2'b00 || s_we !== 0) begin
      nerrors++; $display("FAIL bs_drop: got ack=%b bs=%b we=%b want 0/00/0", m0_ack, s_bs, s_we); end
    tick();
    s_ack = 0; m0_bs = 2'b11; m1_bs = 2'b11; m0_we = 0; #1;
    nchecks++; if (grant !== 2'b00) begin nerrors++; $display("FAIL abort_idle: got %b want 00", grant); end
    tick(); #1;
    nchecks++; if (grant !== 2'b01) begin nerrors++; $display("FAIL abort_keeps_rr: got %b want 01", grant); end
    m0_bs = 0; m1_bs = 0;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 3) m0_bs = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) < 3) m1_bs = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_addr = 16'($urandom); m1_addr = 16'($urandom);
      m0_wdat = 16'($urandom); m1_wdat = 16'($urandom);
      s_rdat = 16'($urandom);
      s_ack = ($urandom_range(0, 9) < 3);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      model_eval();
      nchecks++; if (grant !== exp_grant) begin nerrors++; $display("FAIL rnd_grant c%0d: got %b want %b", c, grant, exp_grant); end
      nchecks++; if ({s_addr, s_wdat, s_bs, s_we} !== {exp_s_addr, exp_s_dat, exp_s_bs, exp_s_we}) begin
        nerrors++; $display("FAIL rnd_slave c%0d: got %h/%h/%b/%b want %h/%h/%b/%b", c, s_addr, s_wdat, s_bs, s_we, exp_s_addr, exp_s_dat, exp_s_bs, exp_s_we); end
      nchecks++; if ({m0_ack, m0_rdat, m1_ack, m1_rdat, tmo} !== {exp_m0_ack, exp_m0_dat, exp_m1_ack, exp_m1_dat, exp_to}) begin
        nerrors++; $display("FAIL rnd_resp c%0d: got %b/%h %b/%h to=%b want %b/%h %b/%h to=%b", c, m0_ack, m0_rdat, m1_ack, m1_rdat, tmo, exp_m0_ack, exp_m0_dat, exp_m1_ack, exp_m1_dat, exp_to); end
      if (exp_m0_ack || exp_m1_ack)
        $display("txn rnd c%0d m%0d addr=%h data=%h timeout=%0d", c, exp_m1_ack ? 1 : 0, exp_s_addr, exp_m1_ack ? exp_m1_dat : exp_m0_dat, exp_to);
      tick();
    end
    rst = 0; idle_inputs();
    tick(); tick();
  endtask

  initial begin
    mdl_owner = 0; mdl_last = 1; mdl_waited = 0;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_m0_read();
    test_back_to_back();
    test_m1_write();
    test_timeout();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
